// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and
// the bit positions of the packed status-flag vector.
package alu_pkg;

  localparam logic [3:0] FN_ADD = 4'd1;
  localparam logic [3:0] FN_SUB = 4'd2;
  localparam logic [3:0] FN_AND = 4'd3;
  localparam logic [3:0] FN_OR  = 4'd4;
  localparam logic [3:0] FN_XOR = 4'd5;
  localparam logic [3:0] FN_SHL = 4'd6;
  localparam logic [3:0] FN_SHR = 4'd7;
  localparam logic [3:0] FN_MUL = 4'd8;
  localparam logic [3:0] FN_DIV = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } alu_state_t;

  localparam int FLAG_Z   = 0;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 2;
  localparam int FLAG_ERR = 3;
  localparam int NFLAGS   = 4;

  function automatic logic is_iter(input logic [3:0] f);
    return (f == FN_MUL) || (f == FN_DIV);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared MUL/DIV iteration datapath: one shift-add or restoring-divide step
// per cycle for WIDTH cycles after start; lo/hi hold product or quotient/remainder.
module alu_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [WIDTH-1:0] acc, sr, opd;
  logic [CW-1:0]    cnt;
  logic             mode_r;
  logic [WIDTH:0]   add_sum, shifted, trial;
  logic [WIDTH-1:0] acc_nxt, sr_nxt;

  // mode_r = 0: {acc, sr} shifts right with the multiplicand added into acc.
  // mode_r = 1: {acc, sr} shifts left, quotient bits enter sr from the right.
  always_comb begin
    add_sum = {1'b0, acc} + {1'b0, opd};
    shifted = {acc, sr[WIDTH-1]};
    trial   = shifted - {1'b0, opd};
    acc_nxt = acc;
    sr_nxt  = sr;
    if (mode_r) begin
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
        sr_nxt  = {sr[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        sr_nxt  = {sr[WIDTH-2:0], 1'b0};
      end
    end else if (sr[0]) begin
      acc_nxt = add_sum[WIDTH:1];
      sr_nxt  = {add_sum[0], sr[WIDTH-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[WIDTH-1:1]};
      sr_nxt  = {acc[0], sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      sr     <= '0;
      opd    <= '0;
      mode_r <= 1'b0;
      cnt    <= LAST;
    end else if (start) begin
      acc    <= '0;
      sr     <= a;
      opd    <= b;
      mode_r <= mode;
      cnt    <= '0;
    end else if (cnt != LAST) begin
      acc <= acc_nxt;
      sr  <= sr_nxt;
      cnt <= cnt + CW'(1);
    end
  end

  assign done = (cnt == LAST);
  assign lo   = sr;
  assign hi   = acc;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides, registered results and flags,
// single-cycle logic/arith ops and iterative MUL/DIV via alu_iter_unit.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err,
  output logic [1:0]       state_dbg
);
  import alu_pkg::*;

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  alu_state_t        state, state_nxt;
  logic              accept, capture, iter_start, iter_done;
  logic [WIDTH-1:0]  a_r, b_r, iter_lo, iter_hi, res_c, hi_c;
  logic [3:0]        func_r;
  logic [WIDTH:0]    add_w, sub_w;
  logic [NFLAGS-1:0] flags_c, flags_r;

  // Handshake: a transfer happens on any edge where valid && ready are both
  // high; in_ready is high only in IDLE, out_valid holds with all outputs
  // stable until out_ready, and in_ready returns on the edge out_valid drops.
  assign in_ready   = (state == IDLE);
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && is_iter(func);
  assign capture    = (state == ONE) || ((state == BUSY) && iter_done);
  assign state_dbg  = state;

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (iter_start),
    .mode  (func == FN_DIV),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .lo    (iter_lo),
    .hi    (iter_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_iter(func) ? BUSY : ONE;
      ONE:     state_nxt = DONE;
      BUSY:    if (iter_done) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    add_w   = {1'b0, a_r} + {1'b0, b_r};
    sub_w   = {1'b0, a_r} - {1'b0, b_r};
    res_c   = '0;
    hi_c    = '0;
    flags_c = '0;
    case (func_r)
      FN_ADD: begin
        res_c           = add_w[WIDTH-1:0];
        flags_c[FLAG_C] = add_w[WIDTH];
        flags_c[FLAG_V] = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_w[WIDTH-1] != a_r[WIDTH-1]);
      end
      FN_SUB: begin
        res_c           = sub_w[WIDTH-1:0];
        flags_c[FLAG_C] = sub_w[WIDTH];
        flags_c[FLAG_V] = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sub_w[WIDTH-1] != a_r[WIDTH-1]);
      end
      FN_AND: res_c = a_r & b_r;
      FN_OR:  res_c = a_r | b_r;
      FN_XOR: res_c = a_r ^ b_r;
      FN_SHL: res_c = (b_r >= WLIM) ? '0 : (a_r << b_r[SW-1:0]);
      FN_SHR: res_c = (b_r >= WLIM) ? '0 : (a_r >> b_r[SW-1:0]);
      FN_MUL: begin
        res_c           = iter_lo;
        hi_c            = iter_hi;
        flags_c[FLAG_C] = |iter_hi;
      end
      FN_DIV: begin
        res_c             = iter_lo;
        hi_c              = iter_hi;
        flags_c[FLAG_ERR] = (b_r == '0);
      end
      default: flags_c[FLAG_ERR] = 1'b1;
    endcase
    flags_c[FLAG_Z] = (res_c == '0);
  end

  // out_valid trails entry into DONE by one edge, so results are settled in
  // the output registers a full cycle before they are offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      func_r    <= '0;
      result    <= '0;
      result_hi <= '0;
      flags_r   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_r    <= a;
        b_r    <= b;
        func_r <= func;
      end
      if (capture) begin
        result    <= res_c;
        result_hi <= hi_c;
        flags_r   <= flags_c;
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
      else if (state == DONE)     out_valid <= 1'b1;
    end
  end

  assign flag_z   = flags_r[FLAG_Z];
  assign flag_c   = flags_r[FLAG_C];
  assign flag_v   = flags_r[FLAG_V];
  assign flag_err = flags_r[FLAG_ERR];

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=16): driver tasks push hand-computed
// expectations, a negedge monitor pops and compares whenever out_valid is high.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result, result_hi;
  logic [3:0]   func;
  logic         flag_z, flag_c, flag_v, flag_err;
  logic [1:0]   state_dbg;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_err  (flag_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // expectation word: {latency[7:0], flags {err,v,c,z}, result_hi, result}
  logic [43:0] exp_q[$];
  int          acc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver tasks (inputs change at posedge+2) ----------------
  task automatic issue(input logic [3:0] f, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] er, input logic [W-1:0] eh, input logic [3:0] ef,
                       input bit track);
    int n = 0;
    logic [7:0] lat;
    while (!in_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout_in_ready", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    a = ia;
    b = ib;
    func = f;
    @(posedge clk); #1;
    lat = (f == FN_MUL || f == FN_DIV) ? 8'(W + 2) : 8'd2;
    if (track) begin
      exp_q.push_back({lat, ef, eh, er});
      acc_q.push_back(cyc);
    end
    #1;
    in_valid = 1'b0;
    a = W'($urandom_range(0, 65535));
    b = W'($urandom_range(0, 65535));
    func = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() > 0 || !in_ready) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  logic [43:0] cur = '0;
  bit          have_cur = 1'b0;
  bit          hs_prev = 1'b0;
  int          acc_c;

  always @(negedge clk) begin
    if (rst) begin
      hs_prev  = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (hs_prev) begin
        chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
        chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
      end
      if (out_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: actual result %0h required no output", result);
            cur = '0;
          end else begin
            cur   = exp_q.pop_front();
            acc_c = acc_q.pop_front();
            chk("latency", 32'(cyc - acc_c), 32'(cur[43:36]));
          end
          have_cur = 1'b1;
        end
        chk("result", 32'(result), 32'(cur[15:0]));
        chk("result_hi", 32'(result_hi), 32'(cur[31:16]));
        chk("flags_err_v_c_z", 32'({flag_err, flag_v, flag_c, flag_z}), 32'(cur[35:32]));
        chk("in_ready_while_valid", 32'(in_ready), 32'd0);
        hs_prev = out_ready;
        if (out_ready) have_cur = 1'b0;
      end else begin
        hs_prev = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_result_hi"}, 32'(result_hi), 32'd0);
    chk({tag, "_flags"}, 32'({flag_err, flag_v, flag_c, flag_z}), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    func = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #1;
    rst = 1'b0;

    // flags argument order: {err, v, c, z}
    issue(FN_ADD, 16'd20,   16'd38,   16'd58,   16'h0000, 4'b0000, 1'b1);
    issue(FN_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0100, 1'b1);
    issue(FN_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0011, 1'b1);
    issue(FN_SUB, 16'd5,    16'd8,    16'hFFFD, 16'h0000, 4'b0010, 1'b1);
    issue(FN_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0100, 1'b1);
    issue(FN_AND, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 4'b0000, 1'b1);
    issue(FN_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 4'b0000, 1'b1);
    issue(FN_XOR, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'b0001, 1'b1);
    issue(FN_SHL, 16'h0001, 16'd20,   16'h0000, 16'h0000, 4'b0001, 1'b1);
    issue(FN_SHL, 16'h0001, 16'd15,   16'h8000, 16'h0000, 4'b0000, 1'b1);
    issue(FN_SHR, 16'h8000, 16'd15,   16'h0001, 16'h0000, 4'b0000, 1'b1);
    issue(FN_SHR, 16'h8000, 16'd16,   16'h0000, 16'h0000, 4'b0001, 1'b1);
    issue(FN_MUL, 16'd300,  16'd300,  16'h5F90, 16'h0001, 4'b0010, 1'b1);
    issue(FN_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0010, 1'b1);
    issue(FN_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 1'b1);
    issue(FN_DIV, 16'd5,    16'd0,    16'hFFFF, 16'd5,    4'b1000, 1'b1);
    issue(4'd12,  16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b1001, 1'b1);
    issue(4'd0,   16'h0001, 16'h0001, 16'h0000, 16'h0000, 4'b1001, 1'b1);
    wait_drain();

    // backpressure: hold out_ready low for 3 cycles once the result is offered
    out_ready = 1'b0;
    issue(FN_ADD, 16'd1, 16'd1, 16'd2, 16'h0000, 4'b0000, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("backpressure_out_valid_seen", 32'(out_valid), 32'd1);
    repeat (3) begin
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    wait_drain();

    // reset in the middle of a MUL abandons it
    issue(FN_MUL, 16'd300, 16'd300, 16'h0, 16'h0, 4'b0000, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid_busy_reset");
    #1;
    rst = 1'b0;
    issue(FN_ADD, 16'd3, 16'd4, 16'd7, 16'h0000, 4'b0000, 1'b1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
